// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers.
// Used by the event counter and the display formatting blocks.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DIGITS = 8;

  typedef logic [BCD_DIGIT_W-1:0] bcd_nibble_t;

  localparam bcd_nibble_t BCD_NINE = 4'd9;
  localparam bcd_nibble_t BCD_ZERO = 4'd0;

  function automatic logic is_nine(
    input bcd_nibble_t nibble
  );
    return nibble == BCD_NINE;
  endfunction

  function automatic bcd_nibble_t bcd_next(
    input bcd_nibble_t nibble
  );
    return is_nine(nibble)
      ? BCD_ZERO
      : nibble + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the event counter.
// Steps on carry_in unless held; rolls 9 -> 0.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        carry_in,
  input  logic        hold,
  output bcd_nibble_t value,
  output logic        carry_out
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= BCD_ZERO;
    end else if (clear) begin
      value <= BCD_ZERO;
    end else if (carry_in && !hold) begin
      value <= bcd_next(value);
    end
  end

  assign carry_out = carry_in & is_nine(value);

`ifndef SYNTHESIS
  a_legal_bcd: assert property (
    @(posedge clock) value <= BCD_NINE
  );
`endif

endmodule

// File: rtl/bcd_counter_ext.sv
// Packed BCD event counter, wrap or saturate,
// with sticky overflow and pre-update snapshot.
module bcd_counter_ext
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  input  logic                  latch,
  output logic [4*DIGITS-1:0]   bcdcount,
  output logic [4*DIGITS-1:0]   bcdheld,
  output logic                  overflow,
  output logic                  at_max
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  generate
    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
      $error("bcd_counter_ext: DIGITS must be 1..8");
    end
  endgenerate

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] nine;
  logic              hold;
  logic              roll;

  assign carry[0] = inc;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .carry_in  (carry[k]),
      .hold      (hold),
      .value     (bcdcount[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry_out (carry[k+1])
    );
    assign nine[k] = is_nine(
      bcdcount[k*BCD_DIGIT_W +: BCD_DIGIT_W]
    );
  end

  assign at_max = &nine;
  assign hold   = SATURATE & at_max;

  // Carry out of the top decade means an increment at all-nine,
  // whether it wrapped or was held back by saturation.
  assign roll = carry[DIGITS];

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (roll) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcdheld <= '0;
    end else if (latch) begin
      bcdheld <= bcdcount;
    end
  end

`ifndef SYNTHESIS
  a_width: assert property (
    @(posedge clock) $bits(bcdcount) == W
  );
`endif

endmodule

// File: tb/tb_bcd_counter_ext.sv
// Random plus directed bench for bcd_counter_ext.
// Three instances share stimulus; an integer model predicts each.
module tb_bcd_counter_ext;

  logic clock = 1'b0;
  logic reset, clear, inc, latch;

  logic [23:0] c6, h6;
  logic [11:0] cs, hs, cw, hw;
  logic ov6, ovs, ovw;
  logic am6, ams, amw;

  int nrun  = 0;
  int nfail = 0;

  int cnt [3];
  bit ov  [3];
  int held[3];
  int maxv[3] = '{999999, 999, 999};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clock = ~clock;

  bcd_counter_ext #(.DIGITS(6), .SATURATE(1'b0)) u_w6 (
    .clock(clock), .reset(reset), .clear(clear),
    .inc(inc), .latch(latch),
    .bcdcount(c6), .bcdheld(h6),
    .overflow(ov6), .at_max(am6)
  );

  bcd_counter_ext #(.DIGITS(3), .SATURATE(1'b1)) u_s3 (
    .clock(clock), .reset(reset), .clear(clear),
    .inc(inc), .latch(latch),
    .bcdcount(cs), .bcdheld(hs),
    .overflow(ovs), .at_max(ams)
  );

  bcd_counter_ext #(.DIGITS(3), .SATURATE(1'b0)) u_w3 (
    .clock(clock), .reset(reset), .clear(clear),
    .inc(inc), .latch(latch),
    .bcdcount(cw), .bcdheld(hw),
    .overflow(ovw), .at_max(amw)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nrun++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit i, c, l, r);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        cnt[k] = 0; ov[k] = 0; held[k] = 0;
      end else begin
        if (l) held[k] = cnt[k];
        if (c) begin
          cnt[k] = 0; ov[k] = 0;
        end else if (i) begin
          if (cnt[k] == maxv[k]) begin
            ov[k] = 1;
            if (!sat[k]) cnt[k] = 0;
          end else begin
            cnt[k] = cnt[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("w6.count", 32'(c6), to_bcd(cnt[0]));
    chk("w6.held",  32'(h6), to_bcd(held[0]));
    chk("w6.ovf",   32'(ov6), 32'(ov[0]));
    chk("w6.max",   32'(am6), 32'(cnt[0] == maxv[0]));
    chk("s3.count", 32'(cs), to_bcd(cnt[1]));
    chk("s3.held",  32'(hs), to_bcd(held[1]));
    chk("s3.ovf",   32'(ovs), 32'(ov[1]));
    chk("s3.max",   32'(ams), 32'(cnt[1] == maxv[1]));
    chk("w3.count", 32'(cw), to_bcd(cnt[2]));
    chk("w3.held",  32'(hw), to_bcd(held[2]));
    chk("w3.ovf",   32'(ovw), 32'(ov[2]));
    chk("w3.max",   32'(amw), 32'(cnt[2] == maxv[2]));
  endtask

  task automatic step(input bit i, c, l, r);
    inc = i; clear = c; latch = l; reset = r;
    @(posedge clock);
    model_edge(i, c, l, r);
    #1;
    check_all();
  endtask

  task automatic run_inc(input int n);
    for (int j = 0; j < n; j++) step(1, 0, 0, 0);
  endtask

  initial begin
    inc = 0; clear = 0; latch = 0; reset = 1;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; ov[k] = 0; held[k] = 0;
    end

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst.count", 32'(c6), 32'h0);
    chk("rst.held",  32'(h6), 32'h0);
    chk("rst.ovf",   32'(ov6), 32'h0);
    chk("rst.max",   32'(am6), 32'h0);

    for (int j = 0; j < 1234; j++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("n1234.count", 32'(c6), 32'h001234);
    step(1, 0, 1, 0);
    chk("lat_inc.held",  32'(h6), 32'h001234);
    chk("lat_inc.count", 32'(c6), 32'h001235);

    step(0, 1, 0, 0);
    run_inc(999);
    chk("w3.at999",  32'(amw), 32'h1);
    chk("s3.at999",  32'(ams), 32'h1);
    step(1, 0, 0, 0);
    chk("w3.wrap",   32'(cw), 32'h000);
    chk("w3.wovf",   32'(ovw), 32'h1);
    chk("w3.wmax",   32'(amw), 32'h0);
    run_inc(4);
    chk("s3.sat",    32'(cs), 32'h999);
    chk("s3.sovf",   32'(ovs), 32'h1);
    chk("w3.sticky", 32'(ovw), 32'h1);
    step(0, 1, 0, 0);
    chk("s3.clr",    32'(cs), 32'h000);
    chk("s3.clrovf", 32'(ovs), 32'h0);

    run_inc(587);
    step(1, 1, 1, 0);
    chk("cli.held",  32'(h6), 32'h000587);
    chk("cli.count", 32'(c6), 32'h000000);

    for (int j = 0; j < 6000; j++) begin
      step($urandom_range(3, 0) != 0,
           $urandom_range(2047, 0) == 0,
           $urandom_range(7, 0) == 0,
           $urandom_range(1023, 0) == 0);
    end

    for (int j = 0; j < 20000; j++) begin
      if (j == 10000) begin
        step(1, 0, 0, 1);
        chk("mid_rst.count", 32'(c6), 32'h0);
        chk("mid_rst.held",  32'(h6), 32'h0);
      end else begin
        step(1, 0, j % 97 == 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
